// File: rtl/audio_frame_bridge_pkg.sv
// audio_bridge_pkg: shared widths, frame type and the RX attenuate-and-narrow helper.
package audio_bridge_pkg;
    localparam int DATA_W = 24;
    localparam int DSP_W  = 16;
    localparam int NUM_CH = 2;
    localparam int CH_W   = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    typedef logic [NUM_CH-1:0][DSP_W-1:0] frame_t;

    // Shift amounts past the sample width clamp to a full sign fill.
    function automatic logic [DSP_W-1:0] narrow(input logic [DATA_W-1:0] w, input int unsigned sh);
        int unsigned s;
        logic signed [DATA_W-1:0] x;
        s = sh >= DATA_W ? DATA_W - 1 : sh;
        x = $signed(w) >>> s;
        return x[DATA_W-1 -: DSP_W];
    endfunction
endpackage

// File: rtl/audio_frame_bridge_if.sv
// audio_frame_bridge_if: codec strobes, DSP RX stream and DSP return stream.
interface audio_frame_bridge_if;
    import audio_bridge_pkg::*;
    logic [31:0] rx_dat_i;
    logic        rx_strobe_i;
    logic        tx_req_i;
    logic [31:0] tx_dat_o;
    logic        dsp_valid_o;
    logic        dsp_ready_i;
    frame_t      dsp_dat_o;
    logic        ret_valid_i;
    frame_t      ret_dat_i;
    logic        ret_ready_o;

    modport master (
        input  rx_dat_i, rx_strobe_i, tx_req_i, dsp_ready_i, ret_valid_i, ret_dat_i,
        output tx_dat_o, dsp_valid_o, dsp_dat_o, ret_ready_o
    );
    modport slave (
        output rx_dat_i, rx_strobe_i, tx_req_i, dsp_ready_i, ret_valid_i, ret_dat_i,
        input  tx_dat_o, dsp_valid_o, dsp_dat_o, ret_ready_o
    );
endinterface

// File: rtl/audio_frame_bridge_fifo.sv
// audio_frame_fifo: frame FIFO with flush; a push into a full FIFO is taken when a pop coincides.
module audio_frame_fifo
    import audio_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush_i,
    input  logic   push_i,
    input  logic   pop_i,
    input  frame_t dat_i,
    output frame_t dat_o,
    output logic   full_o,
    output logic   empty_o
);
    localparam int AW = $clog2(DEPTH);

    frame_t        mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr_en, rd_en;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign dat_o   = mem_q[rd_q];

    always_comb begin
        rd_en = pop_i && !empty_o;
        wr_en = push_i && (!full_o || rd_en);
        wr_d  = flush_i ? '0 : wr_q + AW'(wr_en);
        rd_d  = flush_i ? '0 : rd_q + AW'(rd_en);
        cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush_i) mem_q[wr_q] <= dat_i;
    end
endmodule

// File: rtl/audio_frame_bridge.sv
// audio_frame_bridge: codec <-> DSP frame bridge with attenuation, RX FIFO and TX playback.
// Optional BRIDGE_LOOPBACK_EN adds loopback_i routing RX frames straight into the return buffer.
module audio_frame_bridge
    import audio_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SHIFT_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               clr_stats_i,
`ifdef BRIDGE_LOOPBACK_EN
    input  logic               loopback_i,
`endif
    audio_frame_bridge_if.master bus,
    output logic [7:0]         overrun_cnt_o,
    output logic [7:0]         underrun_cnt_o
);
    localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

    frame_t          rx_frame_q, rx_frame_d, ret_buf_q, ret_buf_d, play_q, play_d, fifo_dat;
    logic [CH_W-1:0] rx_ch_q, rx_ch_d, tx_ch_q, tx_ch_d;
    logic            push_q, push_d, ret_full_q, ret_full_d;
    logic [7:0]      ovr_q, ovr_d, und_q, und_d;
    logic            lb, full, empty, pop, drop, load, ret_acc, rx_last, tx_last;
    logic [DSP_W-1:0] tx_smp;
    logic            unused_rx_hi;

`ifdef BRIDGE_LOOPBACK_EN
    assign lb = loopback_i;
`else
    assign lb = 1'b0;
`endif

    assign unused_rx_hi = ^bus.rx_dat_i[31:DATA_W];
    assign rx_last      = bus.rx_strobe_i && rx_ch_q == LAST;
    assign tx_last      = bus.tx_req_i && tx_ch_q == LAST;
    assign pop          = bus.dsp_valid_o && bus.dsp_ready_i;
    assign drop         = en_i && push_q && !lb && full && !pop;
    assign load         = en_i && tx_last && ret_full_q;
    assign ret_acc      = bus.ret_valid_i && bus.ret_ready_o;

    audio_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (!en_i),
        .push_i  (push_q && !lb),
        .pop_i   (pop),
        .dat_i   (rx_frame_q),
        .dat_o   (fifo_dat),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        rx_frame_d = rx_frame_q;
        ret_buf_d  = ret_buf_q;
        play_d     = play_q;
        rx_ch_d    = rx_ch_q;
        tx_ch_d    = tx_ch_q;
        push_d     = 1'b0;
        ret_full_d = ret_full_q;
        if (!en_i) begin
            rx_ch_d    = '0;
            tx_ch_d    = '0;
            ret_full_d = 1'b0;
        end else begin
            if (bus.rx_strobe_i) begin
                rx_frame_d[rx_ch_q] = narrow(bus.rx_dat_i[DATA_W-1:0], int'(shift_i));
                rx_ch_d = rx_last ? '0 : rx_ch_q + CH_W'(1);
            end
            push_d = rx_last;
            if (bus.tx_req_i) tx_ch_d = tx_last ? '0 : tx_ch_q + CH_W'(1);
            if (load) play_d = ret_buf_q;
            // A loopback frame overwrites the buffer even while a playback load frees it.
            if (push_q && lb) begin
                ret_buf_d  = rx_frame_q;
                ret_full_d = 1'b1;
            end else if (ret_acc) begin
                ret_buf_d  = bus.ret_dat_i;
                ret_full_d = 1'b1;
            end else if (load) begin
                ret_full_d = 1'b0;
            end
        end
        ovr_d = clr_stats_i ? '0 : (drop && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;
        und_d = clr_stats_i ? '0 :
                (en_i && tx_last && !ret_full_q && und_q != 8'hFF) ? und_q + 8'd1 : und_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_frame_q <= '0;
            ret_buf_q  <= '0;
            play_q     <= '0;
            rx_ch_q    <= '0;
            tx_ch_q    <= '0;
            push_q     <= 1'b0;
            ret_full_q <= 1'b0;
            ovr_q      <= '0;
            und_q      <= '0;
        end else begin
            rx_frame_q <= rx_frame_d;
            ret_buf_q  <= ret_buf_d;
            play_q     <= play_d;
            rx_ch_q    <= rx_ch_d;
            tx_ch_q    <= tx_ch_d;
            push_q     <= push_d;
            ret_full_q <= ret_full_d;
            ovr_q      <= ovr_d;
            und_q      <= und_d;
        end
    end

    assign tx_smp          = play_q[tx_ch_q];
    assign bus.tx_dat_o    = en_i ? 32'($signed(tx_smp)) << (DATA_W - DSP_W) : '0;
    assign bus.dsp_valid_o = en_i && !empty && !lb;
    assign bus.dsp_dat_o   = bus.dsp_valid_o ? fifo_dat : '0;
    assign bus.ret_ready_o = en_i && !reset && !ret_full_q && !lb;
    assign overrun_cnt_o   = en_i ? ovr_q : '0;
    assign underrun_cnt_o  = en_i ? und_q : '0;
endmodule

// File: tb/tb_audio_frame_bridge.sv
// tb_audio_frame_bridge: directed stimulus with queued expectations checked by an output monitor.
module tb_audio_frame_bridge;
    import audio_bridge_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en_i = 1'b1;
    logic [4:0] shift_i = '0;
    logic       clr_stats_i = 1'b0;
    logic [7:0] overrun_cnt_o, underrun_cnt_o;
    int         errors = 0;
    int         checks = 0;
    frame_t     dsp_q[$];
    logic [31:0] tx_q[$];

    audio_frame_bridge_if bus();

    audio_frame_bridge #(.FIFO_DEPTH(4), .SHIFT_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .en_i           (en_i),
        .shift_i        (shift_i),
        .clr_stats_i    (clr_stats_i),
        .bus            (bus),
        .overrun_cnt_o  (overrun_cnt_o),
        .underrun_cnt_o (underrun_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.dsp_valid_o && bus.dsp_ready_i) begin
            if (dsp_q.size() == 0) chk("dsp_unexpected", 64'(bus.dsp_dat_o), 64'hDEAD);
            else chk("dsp_frame", 64'(bus.dsp_dat_o), 64'(dsp_q.pop_front()));
        end
        if (bus.tx_req_i) begin
            if (tx_q.size() == 0) chk("tx_unexpected", 64'(bus.tx_dat_o), 64'hDEAD);
            else chk("tx_word", 64'(bus.tx_dat_o), 64'(tx_q.pop_front()));
        end
    end

    function automatic logic [31:0] w(input logic [15:0] v);
        return {8'h00, v, 8'h00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] d);
        bus.rx_dat_i = d;
        bus.rx_strobe_i = 1'b1;
        tick();
        bus.rx_strobe_i = 1'b0;
    endtask

    task automatic frame(input logic [31:0] c0, input logic [31:0] c1);
        strobe(c0);
        strobe(c1);
    endtask

    task automatic txreq(input logic [31:0] exp);
        tx_q.push_back(exp);
        bus.tx_req_i = 1'b1;
        tick();
        bus.tx_req_i = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.dsp_ready_i = 1'b1;
        repeat (n) tick();
        bus.dsp_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_dat_i = '0; bus.rx_strobe_i = 0; bus.tx_req_i = 0;
        bus.dsp_ready_i = 0; bus.ret_valid_i = 0; bus.ret_dat_i = '0;
        tick(); tick();
        chk("rst_ret_ready", 64'(bus.ret_ready_o), 64'd0);
        chk("rst_dsp_valid", 64'(bus.dsp_valid_o), 64'd0);
        chk("rst_tx_dat", 64'(bus.tx_dat_o), 64'd0);
        reset = 1'b0;
        tick();
        chk("ret_ready_idle", 64'(bus.ret_ready_o), 64'd1);

        // attenuation by 3, then saturated shift with upper codec bits ignored
        shift_i = 5'd3;
        dsp_q.push_back({16'hF000, 16'h0FFF});
        frame(32'h007FFFF8, 32'h00800000);
        chk("valid_t1", 64'(bus.dsp_valid_o), 64'd0);
        tick();
        chk("valid_t2", 64'(bus.dsp_valid_o), 64'd1);
        chk("dsp_hold", 64'(bus.dsp_dat_o), 64'({16'hF000, 16'h0FFF}));
        drain(1);
        shift_i = 5'd31;
        dsp_q.push_back({16'h0000, 16'hFFFF});
        frame(32'hAB800000, 32'h007FFFFF);
        tick();
        drain(1);
        tick();
        chk("valid_drained", 64'(bus.dsp_valid_o), 64'd0);

        // six frames into a four-deep FIFO
        shift_i = 5'd0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) dsp_q.push_back({16'h2000 + 16'(k), 16'h1000 + 16'(k)});
            frame(w(16'h1000 + 16'(k)), w(16'h2000 + 16'(k)));
        end
        tick(); tick();
        chk("overrun_2", 64'(overrun_cnt_o), 64'd2);
        drain(6);
        chk("fifo_empty", 64'(bus.dsp_valid_o), 64'd0);

        // playback load and underrun repeat
        bus.ret_dat_i = {16'h1234, 16'hFEDC};
        bus.ret_valid_i = 1'b1;
        tick();
        bus.ret_valid_i = 1'b0;
        chk("ret_full", 64'(bus.ret_ready_o), 64'd0);
        txreq(32'h0); txreq(32'h0);
        chk("ret_freed", 64'(bus.ret_ready_o), 64'd1);
        txreq(32'hFFFEDC00); txreq(32'h00123400);
        chk("underrun_1", 64'(underrun_cnt_o), 64'd1);
        txreq(32'hFFFEDC00); txreq(32'h00123400);
        chk("underrun_2", 64'(underrun_cnt_o), 64'd2);

        // ret_valid held high across a playback load
        bus.ret_dat_i = {16'h0AAA, 16'h0555};
        bus.ret_valid_i = 1'b1;
        tick();
        chk("ret_busy", 64'(bus.ret_ready_o), 64'd0);
        bus.ret_dat_i = {16'h0BBB, 16'h0666};
        tick();
        txreq(32'hFFFEDC00);
        tx_q.push_back(32'h00123400);
        bus.tx_req_i = 1'b1;
        chk("ready_load_cycle", 64'(bus.ret_ready_o), 64'd0);
        tick();
        bus.tx_req_i = 1'b0;
        chk("ready_after_load", 64'(bus.ret_ready_o), 64'd1);
        tick();
        bus.ret_valid_i = 1'b0;
        chk("ready_b_taken", 64'(bus.ret_ready_o), 64'd0);
        txreq(32'h00055500); txreq(32'h000AAA00);
        txreq(32'h00066600); txreq(32'h000BBB00);
        chk("underrun_3", 64'(underrun_cnt_o), 64'd3);

        // reset in the middle of a frame
        strobe(w(16'h1111));
        reset = 1'b1;
        #1;
        chk("mid_rst_tx", 64'(bus.tx_dat_o), 64'd0);
        chk("mid_rst_ready", 64'(bus.ret_ready_o), 64'd0);
        chk("mid_rst_ovr", 64'(overrun_cnt_o), 64'd0);
        chk("mid_rst_und", 64'(underrun_cnt_o), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        dsp_q.push_back({16'h3333, 16'h2222});
        frame(w(16'h2222), w(16'h3333));
        tick();
        drain(1);
        chk("post_rst_empty", 64'(bus.dsp_valid_o), 64'd0);

        // overrun saturation and clear priority
        for (int k = 0; k < 304; k++) frame(w(16'h0001), w(16'h0002));
        tick();
        chk("overrun_sat", 64'(overrun_cnt_o), 64'd255);
        frame(w(16'h0001), w(16'h0002));
        clr_stats_i = 1'b1;
        tick();
        clr_stats_i = 1'b0;
        chk("overrun_clr", 64'(overrun_cnt_o), 64'd0);
        frame(w(16'h0001), w(16'h0002));
        tick();
        chk("overrun_after_clr", 64'(overrun_cnt_o), 64'd1);

        // enable low hides counters and flushes the FIFO
        en_i = 1'b0;
        #1;
        chk("dis_ovr", 64'(overrun_cnt_o), 64'd0);
        chk("dis_valid", 64'(bus.dsp_valid_o), 64'd0);
        tick();
        en_i = 1'b1;
        tick();
        chk("en_ovr_held", 64'(overrun_cnt_o), 64'd1);
        chk("en_flushed", 64'(bus.dsp_valid_o), 64'd0);

        chk("dsp_q_drained", 64'(dsp_q.size()), 64'd0);
        chk("tx_q_drained", 64'(tx_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
